// File: rtl/e_muldiv_unit_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: MDOp codes and FSM states.
// No logic; consumed by e_muldiv_unit and md_arith.
// No flow control of its own.
package e_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for multiple cycles and raise the D-stage hazard.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/e_muldiv_unit_md_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu.
// Zero latency; res_vld low means the result must not be committed (divide by zero).
// No flow control; pure function of its inputs.
module md_arith
    import e_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       md_op,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res,
    output logic             res_vld
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic                      div_zero;
    logic                      div_ovf;
    logic        [WIDTH-1:0]   b_sdiv;
    logic        [WIDTH-1:0]   b_udiv;
    logic signed [WIDTH-1:0]   quo_s;
    logic signed [WIDTH-1:0]   rem_s;
    logic        [WIDTH-1:0]   quo_u;
    logic        [WIDTH-1:0]   rem_u;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Dividing by one yields exactly the required MOST_NEG/-1 answer (q=a, r=0),
    // and keeps the divider away from zero divisors whose result is discarded anyway.
    assign div_zero = (b == '0);
    assign div_ovf  = (a == MOST_NEG) && (b == '1);
    assign b_sdiv   = (div_zero || div_ovf) ? ONE : b;
    assign b_udiv   = div_zero ? ONE : b;

    assign quo_s = $signed(a) / $signed(b_sdiv);
    assign rem_s = $signed(a) % $signed(b_sdiv);
    assign quo_u = a / b_udiv;
    assign rem_u = a % b_udiv;

    always_comb begin
        hi_res  = '0;
        lo_res  = '0;
        res_vld = 1'b0;
        case (md_op_e'(md_op))
            MD_MULT: begin
                hi_res  = prod_s[2*WIDTH-1:WIDTH];
                lo_res  = prod_s[WIDTH-1:0];
                res_vld = 1'b1;
            end
            MD_MULTU: begin
                hi_res  = prod_u[2*WIDTH-1:WIDTH];
                lo_res  = prod_u[WIDTH-1:0];
                res_vld = 1'b1;
            end
            MD_DIV: begin
                hi_res  = rem_s;
                lo_res  = quo_s;
                res_vld = !div_zero;
            end
            MD_DIVU: begin
                hi_res  = rem_u;
                lo_res  = quo_u;
                res_vld = !div_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_muldiv_unit.sv
// E-stage multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// mult: MUL_CYCLES busy cycles, div: DIV_CYCLES busy cycles, mthi/mtlo: 1 edge.
// Busy/MD_Hazard tell the D stage to hold md-class instructions; Start while Busy is ignored.
module e_muldiv_unit
    import e_muldiv_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             MD_Hazard,
    output logic [WIDTH-1:0] HI_out,
    output logic [WIDTH-1:0] LO_out
);

    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] hi_pend_q, lo_pend_q;
    logic             pend_vld_q;
    logic             load_pend;
    logic             commit;

    logic [WIDTH-1:0] hi_res, lo_res;
    logic             res_vld;

    md_arith #(.WIDTH(WIDTH)) u_md_arith (
        .a      (A),
        .b      (B),
        .md_op  (MDOp),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .res_vld(res_vld)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_pend = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start && md_is_arith(MDOp)) begin
                    state_d   = RUN;
                    cnt_d     = md_is_mul(MDOp) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                    load_pend = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            hi_pend_q  <= '0;
            lo_pend_q  <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_pend) begin
                hi_pend_q  <= hi_res;
                lo_pend_q  <= lo_res;
                pend_vld_q <= res_vld;
            end
            // A divide by zero still runs its busy window but leaves HI/LO untouched.
            if (commit && pend_vld_q) begin
                hi_q <= hi_pend_q;
                lo_q <= lo_pend_q;
            end else if (state_q == IDLE && Start) begin
                if (MDOp == MD_MTHI) hi_q <= A;
                if (MDOp == MD_MTLO) lo_q <= A;
            end
        end
    end

    assign Busy      = (state_q == RUN);
    assign MD_Hazard = Busy || (Start && md_is_arith(MDOp));
    assign HI_out    = hi_q;
    assign LO_out    = lo_q;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Scoreboarded random/directed bench for e_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_e_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [2:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, haz;
    logic [W-1:0]  hi, lo;

    logic          rst1, start1;
    logic [2:0]    op1;
    logic [W-1:0]  a1, b1;
    logic          busy1, haz1;
    logic [W-1:0]  hi1, lo1;

    always #5 clk = ~clk;

    e_muldiv_unit #(.WIDTH(W), .MUL_CYCLES(5), .DIV_CYCLES(10)) u_dut (
        .Clk(clk), .Rst(rst), .Start(start), .MDOp(op), .A(a), .B(b),
        .Busy(busy), .MD_Hazard(haz), .HI_out(hi), .LO_out(lo)
    );

    e_muldiv_unit #(.WIDTH(W), .MUL_CYCLES(1), .DIV_CYCLES(2)) u_dut1 (
        .Clk(clk), .Rst(rst1), .Start(start1), .MDOp(op1), .A(a1), .B(b1),
        .Busy(busy1), .MD_Hazard(haz1), .HI_out(hi1), .LO_out(lo1)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           len;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] m_hi, m_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: measures each busy window and compares the HI/LO visible when it closes.
    int run = 0;
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            run++;
        end else if (run > 0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_completion actual_len=%0d required=none", run);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("busy_len", 64'(run), 64'(e.len));
                check("hi_result", 64'(hi), 64'(e.hi));
                check("lo_result", 64'(lo), 64'(e.lo));
            end
            run = 0;
        end
    end

    // Expected HI/LO from the instruction semantics using wide plain arithmetic.
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint       sa, sb, q, r;
        logic [63:0]  p;
        case (o)
            3'd1: begin
                sa = longint'(int'(x));
                sb = longint'(int'(y));
                p  = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2: begin
                p = {32'b0, x} * {32'b0, y};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd3: if (y != 0) begin
                sa = longint'(int'(x));
                sb = longint'(int'(y));
                q  = sa / sb;
                r  = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            3'd4: if (y != 0) begin
                m_lo = x / y;
                m_hi = x % y;
            end
            3'd5: m_hi = x;
            3'd6: m_lo = x;
            default: ;
        endcase
    endtask

    // Called just after a rising edge; returns just after a rising edge with the unit idle.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic arith;
        exp_t e;
        int   n;
        arith = (o >= 3'd1) && (o <= 3'd4);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        model(o, x, y);
        if (arith) begin
            e.hi  = m_hi;
            e.lo  = m_lo;
            e.len = (o <= 3'd2) ? 5 : 10;
            exp_q.push_back(e);
        end
        @(negedge clk);
        check("hazard_start", 64'(haz), 64'(arith));
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        if (arith) begin
            n = 0;
            while (busy !== 1'b0 && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 40) begin
                total++;
                bad++;
                $display("FAIL busy_timeout actual=stuck_busy required=idle_within_40");
            end
        end else begin
            check("busy_no_op", 64'(busy), 64'(0));
            check("hi_write", 64'(hi), 64'(m_hi));
            check("lo_write", 64'(lo), 64'(m_lo));
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        rst1 = 1'b1; start1 = 1'b0; op1 = 3'd0; a1 = '0; b1 = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_hazard", 64'(haz), 64'(0));
        @(posedge clk);
        #1;

        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo_const", 64'(lo), 64'hFFFF_FFFA);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_const", 64'(lo), 64'hFFFF_FFFD);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        check("divu_lo_const", 64'(lo), 64'h7FFF_FFFC);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
        issue(3'd5, 32'h11, 32'h0);
        issue(3'd6, 32'h22, 32'h0);
        issue(3'd3, 32'h1234, 32'h0);
        check("div0_hi_const", 64'(hi), 64'h11);
        check("div0_lo_const", 64'(lo), 64'h22);
        issue(3'd5, 32'hDEAD, 32'h0);
        issue(3'd6, 32'hBEEF, 32'h0);
        issue(3'd0, 32'h5555, 32'h1);
        issue(3'd7, 32'h6666, 32'h2);

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
        end

        // Reset during the third busy cycle of a MULTU: nothing may be committed.
        begin
            exp_t e;
            e.hi = '0; e.lo = '0; e.len = 3;
            exp_q.push_back(e);
        end
        start = 1'b1; op = 3'd2; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'd0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        check("abort_busy", 64'(busy), 64'(0));
        repeat (8) @(posedge clk);
        #1;
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        check("abort_queue_drained", 64'(exp_q.size()), 64'(0));

        // Single-cycle multiply instance.
        rst1 = 1'b0;
        check("dut1_reset_hi", 64'(hi1), 64'(0));
        start1 = 1'b1; op1 = 3'd2; a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF;
        @(negedge clk);
        check("dut1_hazard", 64'(haz1), 64'(1));
        @(posedge clk);
        #1;
        start1 = 1'b0; op1 = 3'd0;
        @(negedge clk);
        check("dut1_busy_cycle1", 64'(busy1), 64'(1));
        @(negedge clk);
        check("dut1_busy_cycle2", 64'(busy1), 64'(0));
        check("dut1_hi", 64'(hi1), 64'hFFFF_FFFE);
        check("dut1_lo", 64'(lo1), 64'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
